// File: rtl/rv_muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_ZERO_BYPASS_EN completes zero-operand ops directly from IDLE.
module rv_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int UNROLL     = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clkEn,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [XLEN-1:0]       opA,
  input  logic [XLEN-1:0]       opB,
  input  logic                  flush,
  output logic                  ready,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out
);

  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = $clog2(N);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

  stateT                 state, nextState;
  logic [CNT_W-1:0]      cnt;
  logic [XLEN-1:0]       hi, lo, opnd, hiN, loN;
  logic [XLEN:0]         sh, diff, sum;
  logic [2:0]            f3Q;
  logic                  negQ, negR;
  logic [REG_ADDR_W-1:0] rdQ;
  logic                  accept, signA, signB, negA, negB, special, bypass;
  logic [XLEN-1:0]       magA, magB, specialRes, quo, remv, fixRes;
  logic [2*XLEN-1:0]     prod;

  assign ready  = (state == IDLE) && !rst;
  assign done   = (state == DONE) && !(flush && clkEn);
  assign accept = start && ready && clkEn && !flush;

`ifdef MULDIV_ZERO_BYPASS_EN
  assign bypass = funct3[2] ? (opA == '0 && opB != '0) : (opA == '0 || opB == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    signA = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    signB = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    negA  = signA && opA[XLEN-1];
    negB  = signB && opB[XLEN-1];
    magA  = negA ? -opA : opA;
    magB  = negB ? -opB : opB;
    special    = 1'b0;
    specialRes = '0;
    if (funct3[2] && opB == '0) begin
      special    = 1'b1;
      specialRes = funct3[1] ? opA : '1;
    end else if (funct3[2] && !funct3[0] && opA == MIN_NEG && opB == '1) begin
      special    = 1'b1;
      specialRes = funct3[1] ? '0 : opA;
    end else if (bypass) begin
      special = 1'b1;
    end
  end

  // hi/lo double as {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    hiN  = hi;
    loN  = lo;
    sh   = '0;
    diff = '0;
    sum  = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (f3Q[2]) begin
        sh   = {hiN, loN[XLEN-1]};
        diff = sh - {1'b0, opnd};
        loN  = {loN[XLEN-2:0], !diff[XLEN]};
        hiN  = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
      end else begin
        sum = {1'b0, hiN} + (loN[0] ? {1'b0, opnd} : '0);
        loN = {sum[0], loN[XLEN-1:1]};
        hiN = sum[XLEN:1];
      end
    end
  end

  always_comb begin
    prod = {hi, lo};
    if (negQ) prod = -prod;
    quo  = negQ ? -lo : lo;
    remv = negR ? -hi : hi;
    case (f3Q)
      3'b000:                 fixRes = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixRes = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fixRes = quo;
      default:                fixRes = remv;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = special ? DONE : CALC;
      CALC: if (cnt == '0) nextState = FIX;
      FIX:  nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (flush) nextState = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (clkEn) state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      f3Q    <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      rdQ    <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (clkEn) begin
      if (accept) begin
        f3Q  <= funct3;
        rdQ  <= rd_in;
        negQ <= negA ^ negB;
        negR <= negA;
        hi   <= '0;
        lo   <= funct3[2] ? magA : magB;
        opnd <= funct3[2] ? magB : magA;
        cnt  <= CNT_W'(N - 1);
        if (special) begin
          result <= specialRes;
          rd_out <= rd_in;
        end
      end else if (state == CALC && !flush) begin
        hi  <= hiN;
        lo  <= loN;
        cnt <= cnt - CNT_W'(1);
      end else if (state == FIX && !flush) begin
        result <= fixRes;
        rd_out <= rdQ;
      end
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed self-checking bench for rv_muldiv_unit: 32-bit/UNROLL=1 and 64-bit/UNROLL=4 instances.
module tb_rv_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clkEn, flush;
  logic start, ready, done;
  logic [2:0] funct3;
  logic [4:0] rdIn, rdOut;
  logic [31:0] opA, opB, result;
  logic start2, ready2, done2;
  logic [2:0] funct3b;
  logic [4:0] rdIn2, rdOut2;
  logic [63:0] opA2, opB2, result2;

  int checks = 0;
  int errors = 0;

  rv_muldiv_unit #(.XLEN(32), .UNROLL(1), .REG_ADDR_W(5)) dut32 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .start(start), .funct3(funct3), .rd_in(rdIn),
    .opA(opA), .opB(opB), .flush(flush), .ready(ready), .done(done), .result(result),
    .rd_out(rdOut));

  rv_muldiv_unit #(.XLEN(64), .UNROLL(4), .REG_ADDR_W(5)) dut64 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .start(start2), .funct3(funct3b), .rd_in(rdIn2),
    .opA(opA2), .opB(opB2), .flush(flush), .ready(ready2), .done(done2), .result(result2),
    .rd_out(rdOut2));

  task automatic run32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int cyc, output logic [31:0] res,
                       output logic [4:0] rdo);
    int w = 0;
    while (ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    funct3 = f3; opA = a; opB = b; rdIn = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    res = result;
    rdo = rdOut;
  endtask

  task automatic run64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, output int cyc, output logic [63:0] res);
    int w = 0;
    while (ready2 !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    funct3b = f3; opA2 = a; opB2 = b; rdIn2 = rd; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 1;
    while (done2 !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    res = result2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (rdOut !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rdOut); end
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready64: got %b expected 0", ready2); end
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", ready); end
  endtask

  task automatic test_mul;
    int cyc; logic [31:0] res; logic [4:0] rdo;
    run32(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, cyc, res, rdo);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL mul_latency: got %0d expected 34", cyc); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
    checks++; if (rdo !== 5'd9) begin errors++; $display("FAIL mul_rd: got %0d expected 9", rdo); end
    run32(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, cyc, res, rdo);
    checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL mulh: got %h expected 40000000", res); end
    run32(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2, cyc, res, rdo);
    checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL mulhu: got %h expected 40000000", res); end
    run32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, cyc, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu: got %h expected ffffffff", res); end
    run32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, cyc, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_max: got %h expected fffffffe", res); end
  endtask

  task automatic test_div;
    int cyc; logic [31:0] res; logic [4:0] rdo;
    run32(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, cyc, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg: got %h expected fffffffd", res); end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL div_latency: got %0d expected 34", cyc); end
    run32(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, cyc, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg: got %h expected ffffffff", res); end
    run32(3'b101, 32'd100, 32'd0, 5'd12, cyc, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero: got %h expected ffffffff", res); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL divu_zero_latency: got %0d expected 1", cyc); end
    checks++; if (rdo !== 5'd12) begin errors++; $display("FAIL divu_zero_rd: got %0d expected 12", rdo); end
    run32(3'b111, 32'd100, 32'd0, 5'd13, cyc, res, rdo);
    checks++; if (res !== 32'd100) begin errors++; $display("FAIL remu_zero: got %h expected 64", res); end
    run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, cyc, res, rdo);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf: got %h expected 0", res); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL rem_ovf_latency: got %0d expected 1", cyc); end
    run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, cyc, res, rdo);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf: got %h expected 80000000", res); end
    run32(3'b111, 32'd100, 32'd7, 5'd16, cyc, res, rdo);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu: got %h expected 2", res); end
  endtask

  task automatic test_flush;
    int cyc; int seen; logic [31:0] res; logic [4:0] rdo;
    run32(3'b101, 32'd100, 32'd7, 5'd3, cyc, res, rdo);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu: got %h expected e", res); end
    @(posedge clk); #1;
    funct3 = 3'b101; opA = 32'd200; opB = 32'd7; rdIn = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", ready); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_result_hold: got %h expected e", result); end
    checks++; if (rdOut !== 5'd3) begin errors++; $display("FAIL flush_rd_hold: got %0d expected 3", rdOut); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done pulses expected 0", seen); end
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_beats_start: got ready %b expected 1", ready); end
    run32(3'b101, 32'd200, 32'd7, 5'd4, cyc, res, rdo);
    checks++; if (res !== 32'd28) begin errors++; $display("FAIL post_flush_result: got %h expected 1c", res); end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL post_flush_latency: got %0d expected 34", cyc); end
  endtask

  task automatic test_clken;
    int cyc;
    @(posedge clk); #1;
    funct3 = 3'b000; opA = 32'd7; opB = 32'hFFFF_FFFD; rdIn = 5'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == 10) clkEn = 1'b0;
      if (cyc == 13) clkEn = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    checks++; if (cyc !== 37) begin errors++; $display("FAIL clken_latency: got %0d expected 37", cyc); end
    checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL clken_result: got %h expected ffffffeb", result); end
    clkEn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clken_done_hold: got %b expected 1", done); end
    clkEn = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clken_done_release: got %b expected 0", done); end
  endtask

  task automatic test_reset_mid;
    int seen;
    funct3 = 3'b101; opA = 32'd100; opB = 32'd7; rdIn = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", result); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_release: got %b expected 1", ready); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done pulses expected 0", seen); end
  endtask

  task automatic test_back_to_back;
    int cyc; logic [31:0] res; logic [4:0] rdo;
    run32(3'b101, 32'd100, 32'd0, 5'd7, cyc, res, rdo);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 0", ready); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b expected 1", ready); end
    run32(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd8, cyc, res, rdo);
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL b2b_result: got %h expected ffffffeb", res); end
    checks++; if (rdo !== 5'd8) begin errors++; $display("FAIL b2b_rd: got %0d expected 8", rdo); end
  endtask

  task automatic test_wide;
    int cyc; int expZero; logic [63:0] res;
`ifdef MULDIV_ZERO_BYPASS_EN
    expZero = 1;
`else
    expZero = 18;
`endif
    run64(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, cyc, res);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL w_mulhu: got %h expected fffffffffffffffe", res); end
    checks++; if (cyc !== 18) begin errors++; $display("FAIL w_mulhu_latency: got %0d expected 18", cyc); end
    run64(3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd2, cyc, res);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF2) begin errors++; $display("FAIL w_div: got %h expected fffffffffffffff2", res); end
    run64(3'b110, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd3, cyc, res);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL w_rem: got %h expected fffffffffffffffe", res); end
    run64(3'b000, 64'd3, 64'd5, 5'd4, cyc, res);
    checks++; if (res !== 64'd15) begin errors++; $display("FAIL w_mul: got %h expected f", res); end
    run64(3'b000, 64'd0, 64'd5, 5'd5, cyc, res);
    checks++; if (res !== 64'd0) begin errors++; $display("FAIL w_mul_zero: got %h expected 0", res); end
    checks++; if (cyc !== expZero) begin errors++; $display("FAIL w_mul_zero_latency: got %0d expected %0d", cyc, expZero); end
    run64(3'b101, 64'd0, 64'd5, 5'd6, cyc, res);
    checks++; if (res !== 64'd0) begin errors++; $display("FAIL w_divu_zero_num: got %h expected 0", res); end
    checks++; if (cyc !== expZero) begin errors++; $display("FAIL w_divu_zero_latency: got %0d expected %0d", cyc, expZero); end
  endtask

  initial begin
    rst = 1'b1; clkEn = 1'b1; flush = 1'b0;
    start = 1'b0; funct3 = '0; rdIn = '0; opA = '0; opB = '0;
    start2 = 1'b0; funct3b = '0; rdIn2 = '0; opA2 = '0; opB2 = '0;
    test_reset;
    test_mul;
    test_div;
    test_flush;
    test_clken;
    test_reset_mid;
    test_back_to_back;
    test_wide;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
